// File: rtl/player_pkg.sv
// Shared definitions for the player vertical-motion engine.
//   state_e : motion FSM states
//   DEF_*   : default screen/sprite geometry and motion tuning
//   line_y  : screen y of platform line k
package player_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_AIR  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  localparam int DEF_N_LINES    = 3;
  localparam int DEF_LINE_Y0    = 120;
  localparam int DEF_LINE_PITCH = 120;
  localparam int DEF_PLAYER_H   = 60;
  localparam int DEF_SCREEN_H   = 480;
  localparam int DEF_Y_W        = 9;
  localparam int DEF_V_MAX      = 4;
  localparam int DEF_ACCEL_DIV  = 4;
  localparam int DEF_START_LINE = 1;

  function automatic int line_y(input int k, input int y0, input int pitch);
    return y0 + k * pitch;
  endfunction

endpackage

// File: rtl/player_motion_landing_finder.sv
// Combinational landing search for the player sprite.
// Ports:
//   height_i   : current sprite top y
//   v_i        : current speed (pixels per tick)
//   grav_dir_i : 0 = down, 1 = up
//   lines_i    : line k present under/over the player
//   hit_o      : the next move reaches or crosses an existing line
//   snap_y_o   : sprite top y when resting on the line that was hit
//   contact_o  : sprite is exactly resting on an existing line now
module landing_finder
  import player_pkg::*;
#(
  parameter int N_LINES    = DEF_N_LINES,
  parameter int LINE_Y0    = DEF_LINE_Y0,
  parameter int LINE_PITCH = DEF_LINE_PITCH,
  parameter int PLAYER_H   = DEF_PLAYER_H,
  parameter int Y_W        = DEF_Y_W,
  parameter int V_W        = 3
) (
  input  logic [Y_W-1:0]     height_i,
  input  logic [V_W-1:0]     v_i,
  input  logic               grav_dir_i,
  input  logic [N_LINES-1:0] lines_i,
  output logic               hit_o,
  output logic [Y_W-1:0]     snap_y_o,
  output logic               contact_o
);

  // Two extra bits so bottom edge plus speed never wraps.
  localparam int CW = Y_W + 2;

  logic [CW-1:0] top;
  logic [CW-1:0] bot;
  logic [CW-1:0] ly [N_LINES];

  assign top = CW'(height_i);
  assign bot = top + CW'(PLAYER_H);

  always_comb begin
    for (int k = 0; k < N_LINES; k++) begin
      ly[k] = CW'(line_y(k, LINE_Y0, LINE_PITCH));
    end
  end

  // Loop direction makes the first line met in the direction of motion
  // the last assignment, so it wins if more than one would qualify.
  always_comb begin
    hit_o     = 1'b0;
    snap_y_o  = '0;
    contact_o = 1'b0;
    if (!grav_dir_i) begin
      for (int k = N_LINES - 1; k >= 0; k--) begin
        if (lines_i[k] && (bot == ly[k])) contact_o = 1'b1;
        if (lines_i[k] && (bot <= ly[k]) && (ly[k] <= bot + CW'(v_i))) begin
          hit_o    = 1'b1;
          snap_y_o = Y_W'(ly[k] - CW'(PLAYER_H));
        end
      end
    end else begin
      for (int k = 0; k < N_LINES; k++) begin
        if (lines_i[k] && (top == ly[k])) contact_o = 1'b1;
        if (lines_i[k] && (ly[k] <= top) && (ly[k] + CW'(v_i) >= top)) begin
          hit_o    = 1'b1;
          snap_y_o = Y_W'(ly[k]);
        end
      end
    end
  end

endmodule

// File: rtl/player_motion.sv
// Vertical-motion engine for the runner's player sprite: gravity flip,
// accelerating fall with speed cap, walk-off, and off-screen death.
// Advances once per tick; all outputs are registered.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   tick           : one-cycle frame enable
//   flip_req       : gravity-flip request pulse (latched until next tick)
//   kill           : external death, level-sensitive
//   lines          : line k present under/over the player
//   height         : sprite top y (y grows downward)
//   grav_dir       : 0 = down, 1 = up
//   grounded       : resting on a line
//   dead           : motion frozen until reset
//   out_of_bounds  : one-cycle pulse when death is from leaving the screen
//
// state   | meaning
// --------+-------------------------------------------
// ST_RUN  | resting on a line, waiting for flip or line loss
// ST_AIR  | airborne, moving by v each tick and accelerating
// ST_DEAD | frozen until reset
module player_motion
  import player_pkg::*;
#(
  parameter int N_LINES    = DEF_N_LINES,
  parameter int LINE_Y0    = DEF_LINE_Y0,
  parameter int LINE_PITCH = DEF_LINE_PITCH,
  parameter int PLAYER_H   = DEF_PLAYER_H,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int Y_W        = DEF_Y_W,
  parameter int V_MAX      = DEF_V_MAX,
  parameter int ACCEL_DIV  = DEF_ACCEL_DIV,
  parameter int START_LINE = DEF_START_LINE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               flip_req,
  input  logic               kill,
  input  logic [N_LINES-1:0] lines,
  output logic [Y_W-1:0]     height,
  output logic               grav_dir,
  output logic               grounded,
  output logic               dead,
  output logic               out_of_bounds
);

  localparam int V_W = $clog2(V_MAX + 1);
  localparam int C_W = $clog2(ACCEL_DIV + 1);
  localparam int W1  = Y_W + 1;

  localparam logic [Y_W-1:0] H_RST =
    Y_W'(line_y(START_LINE, LINE_Y0, LINE_PITCH) - PLAYER_H);
  localparam logic [Y_W-1:0] H_BOT = Y_W'(SCREEN_H - PLAYER_H);

  state_e         state_q;
  logic [Y_W-1:0] height_q;
  logic           grav_q;
  logic           grounded_q;
  logic           dead_q;
  logic           oob_q;
  logic [V_W-1:0] v_q;
  logic [C_W-1:0] cnt_q;
  logic           pend_q;

  logic           hit;
  logic           contact;
  logic [Y_W-1:0] snap_y;
  logic           flip_now;
  logic [W1-1:0]  h_dn_d;
  logic [W1-1:0]  h_up_d;
  logic [Y_W-1:0] h_move_d;
  logic           oob_d;

  landing_finder #(
    .N_LINES    (N_LINES),
    .LINE_Y0    (LINE_Y0),
    .LINE_PITCH (LINE_PITCH),
    .PLAYER_H   (PLAYER_H),
    .Y_W        (Y_W),
    .V_W        (V_W)
  ) u_finder (
    .height_i   (height_q),
    .v_i        (v_q),
    .grav_dir_i (grav_q),
    .lines_i    (lines),
    .hit_o      (hit),
    .snap_y_o   (snap_y),
    .contact_o  (contact)
  );

  // A request arriving on the tick cycle itself counts for that tick.
  assign flip_now = pend_q | flip_req;

  // One extra bit so leaving the screen is caught before clamping.
  assign h_dn_d   = {1'b0, height_q} + W1'(v_q);
  assign h_up_d   = {1'b0, height_q} - W1'(v_q);
  assign h_move_d = grav_q ? h_up_d[Y_W-1:0] : h_dn_d[Y_W-1:0];
  assign oob_d    = grav_q ? ({1'b0, height_q} < W1'(v_q))
                           : ((h_dn_d + W1'(PLAYER_H)) >= W1'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      height_q   <= H_RST;
      grav_q     <= 1'b0;
      grounded_q <= 1'b1;
      dead_q     <= 1'b0;
      oob_q      <= 1'b0;
      v_q        <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      oob_q <= 1'b0;
      if (flip_req) pend_q <= 1'b1;
      if (tick) begin
        pend_q <= 1'b0;
        if ((state_q != ST_DEAD) && kill) begin
          state_q    <= ST_DEAD;
          grounded_q <= 1'b0;
          dead_q     <= 1'b1;
        end else begin
          unique case (state_q)
            ST_RUN: begin
              if (flip_now || !contact) begin
                if (flip_now) grav_q <= ~grav_q;
                state_q    <= ST_AIR;
                grounded_q <= 1'b0;
                v_q        <= V_W'(1);
                cnt_q      <= '0;
              end
            end
            ST_AIR: begin
              if (hit) begin
                state_q    <= ST_RUN;
                height_q   <= snap_y;
                grounded_q <= 1'b1;
                v_q        <= '0;
                cnt_q      <= '0;
              end else if (oob_d) begin
                state_q  <= ST_DEAD;
                height_q <= grav_q ? '0 : H_BOT;
                dead_q   <= 1'b1;
                oob_q    <= 1'b1;
              end else begin
                height_q <= h_move_d;
                if (cnt_q == C_W'(ACCEL_DIV - 1)) begin
                  cnt_q <= '0;
                  if (v_q < V_W'(V_MAX)) v_q <= v_q + V_W'(1);
                end else begin
                  cnt_q <= cnt_q + C_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign height        = height_q;
  assign grav_dir      = grav_q;
  assign grounded      = grounded_q;
  assign dead          = dead_q;
  assign out_of_bounds = oob_q;

endmodule

// File: doc/player_motion.md
# player_motion

Parametrised vertical-motion engine for the runner's player sprite. It supports a configurable number of platform lines, gravity flip on request, accelerating fall with a speed cap, edge walk-off, and out-of-screen death detection. It sits between the input/gravity-control logic and the renderer/collision logic, and advances once per `tick` (frame-rate enable) on the system clock.

## Interface
- `N_LINES`, 3: number of horizontal platform lines; line k lies at y_k = `LINE_Y0` + k·`LINE_PITCH` (k=0 topmost).
- `LINE_Y0`, 120: screen y of line 0.
- `LINE_PITCH`, 120: spacing between lines; must exceed `V_MAX`.
- `PLAYER_H`, 60: sprite height in pixels.
- `SCREEN_H`, 480: visible screen height.
- `Y_W`, 9: width of y coordinates.
- `V_MAX`, 4: maximum speed, pixels per tick.
- `ACCEL_DIV`, 4: number of airborne ticks per +1 speed.
- `START_LINE`, 1: line the player stands on after reset.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `tick`, in, 1: motion enable, one-cycle pulse per frame.
- `flip_req`, in, 1: gravity-flip request pulse; may arrive on any cycle.
- `kill`, in, 1: external death (obstacle hit); level-sensitive.
- `lines`, in, `N_LINES`: bit k=1 means line k exists under/over the player's x position.
- `height`, out, `Y_W`: screen y of the sprite's top-left corner; y grows downward.
- `grav_dir`, out, 1: 0 = down, 1 = up.
- `grounded`, out, 1: player is resting on a line.
- `dead`, out, 1: player is dead; motion frozen.
- `out_of_bounds`, out, 1: one-cycle pulse when death is caused by leaving the screen.

## Operation
- States: RUN (grounded), AIR, DEAD. The state machine is registered, and all outputs are registered.
- Reset values:
  - `height` = y_START_LINE − `PLAYER_H` (180 with defaults)
  - `grav_dir` = 0
  - state RUN; `grounded` = 1; `dead` = 0; `out_of_bounds` = 0
  - speed v = 0; accel counter = 0; flip pending = 0
- Contact condition:
  - Down gravity: contact when `height` + `PLAYER_H` = y_k and `lines[k]` = 1.
  - Up gravity: contact when `height` = y_k and `lines[k]` = 1.
- `flip_req` sets a pending flag on any cycle. The flag is consumed and cleared on the next `tick`.
- On each `tick`, evaluated in priority order:
  1. `kill` = 1: go to DEAD; `height` holds; no `out_of_bounds` pulse.
  2. RUN with a pending flip: toggle `grav_dir`, go to AIR, v = 1, counter = 0. Height does not move on this tick.
  3. RUN with no contact (line vanished): go to AIR, v = 1, counter = 0.
  4. AIR: move `height` by v in the gravity direction. If the swept span crosses or reaches a contact point y_k with `lines[k]` = 1, snap to that contact, go to RUN, and set v = 0. At most one line can be crossed because `V_MAX` < `LINE_PITCH`; take the first line in the direction of motion.
  5. AIR, no landing: counter += 1. When counter reaches `ACCEL_DIV`, v = min(v+1, `V_MAX`) and counter = 0.
  6. Out of bounds:
     - Down: the new `height` + `PLAYER_H` ≥ `SCREEN_H`. Clamp `height` = `SCREEN_H` − `PLAYER_H`.
     - Up: the current `height` < v. Clamp `height` = 0.
     - In both cases go to DEAD and pulse `out_of_bounds`.
- A pending flip in AIR is discarded at the tick (no double jump). A flip in DEAD is ignored.
- DEAD is absorbing until `reset`.
- Arithmetic is done in `Y_W`+1 bits so underflow and overflow are detected before clamping; `height` never wraps.

## Timing
- With `tick` = 0, all state holds, except that the pending flag may be set.
- Outputs update on the clock edge of the `tick` cycle, so latency from `tick` to the new `height` is 1 cycle.
- `flip_req` on the same cycle as `tick` is honoured on that tick.
- `flip_req` and loss of the line on the same tick: the flip wins.
- `kill` and a flip on the same tick: `kill` wins.
- `out_of_bounds` is high for exactly one clock cycle, coincident with `dead` rising.
- `reset` mid-operation, including in AIR or DEAD, restores all reset values on the next edge regardless of `tick`.

## Structure
- Package `player_pkg`:
  - state enum {RUN, AIR, DEAD}
  - function `line_y(k)`
  - default geometry constants
- Sub-module `landing_finder`, combinational:
  - Inputs: `height`, v, `grav_dir`, `lines`.
  - Outputs: `hit`, snap y, and `contact` (for the RUN check).
  - The remaining logic (FSM, speed/acceleration counter, pending flag, bounds check) lives in `player_motion`.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `reset` for 2 cycles → `height` = 180, `grav_dir` = 0, `grounded` = 1, `dead` = 0. Hold `lines` = 3'b111 for 10 ticks → `height` stays 180.
- **Flip up:** at rest, pulse `flip_req` between ticks, `lines` = 3'b111 → `grav_dir` = 1. The following ticks give `height` 179, 178, 177, 176, 174, … (speed 1→2→3→4), then snap to exactly 120 with `grounded` = 1. A second `flip_req` issued while airborne → ignored.
- **Walk-off:** at 180, down gravity, set `lines` = 3'b100 → AIR. Fall accelerates and lands at `height` = 300 (bottom at 360), `grounded` = 1, with no overshoot.
- **Fall out:** at 300, set `lines` = 3'b000 → `height` clamps to 420, `dead` = 1, `out_of_bounds` high for 1 cycle. Further ticks and flips leave `height` = 420.
- **Up out:** flip from 180 with `lines` = 3'b000 → `height` clamps to 0, `dead` = 1, `out_of_bounds` pulses.
- **Kill and reset:** `kill` in AIR → `dead` = 1, `height` frozen, no `out_of_bounds`. Then `reset` mid-air → `height` = 180, `grav_dir` = 0, pending flip cleared.
